// File: rtl/gray_code_counter.sv
// gray_code_counter: N-bit up/down counter publishing registered binary and Gray code.
// Define GRAY_CHECK_EN to add the sticky gray_err single-bit-change monitor.
module gray_code_counter #(
   parameter int N = 4,
   parameter int RESET_VALUE = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         up,
   input  logic         load,
   input  logic [N-1:0] load_value,
   output logic [N-1:0] binary_value,
   output logic [N-1:0] gray_value,
   output logic         wrap
`ifdef GRAY_CHECK_EN
   ,
   output logic         gray_err
`endif
);
   localparam logic [N-1:0] RV = N'(RESET_VALUE);
   logic [N-1:0] next_bin, next_gray, load_gray;
   logic         step_wrap;
   always_comb begin
      next_bin  = up ? binary_value + N'(1) : binary_value - N'(1);
      next_gray = next_bin ^ (next_bin >> 1);
      load_gray = load_value ^ (load_value >> 1);
      step_wrap = up ? &binary_value : ~|binary_value;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         binary_value <= RV;
         gray_value   <= RV ^ (RV >> 1);
         wrap         <= 1'b0;
      end else if (load) begin
         binary_value <= load_value;
         gray_value   <= load_gray;
         wrap         <= 1'b0;
      end else if (en) begin
         binary_value <= next_bin;
         gray_value   <= next_gray;
         wrap         <= step_wrap;
      end else begin
         wrap         <= 1'b0;
      end
   end
`ifdef GRAY_CHECK_EN
   // Compare the stepped code against the code actually held, so a corrupted register is caught
   logic [N-1:0] diff;
   always_comb diff = next_gray ^ gray_value;
   always_ff @(posedge clk) begin
      if (rst) gray_err <= 1'b0;
      else if (en && !load && (diff == '0 || (diff & (diff - N'(1))) != '0)) gray_err <= 1'b1;
   end
`endif
endmodule
